// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one downstream memory port among several core-side buses.
// Each master raises req and holds it until its one-cycle ready pulse. The arbiter
// grants in IDLE, optionally waits a fixed number of cycles, issues a single-cycle
// downstream strobe (or flags an out-of-range error), then answers in RESP.
module mem_bus_arbiter #(
    parameter int                NUM_MASTERS = 2,
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                MASK_W      = DATA_W / 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(32'h8000_0000),
    parameter logic [ADDR_W-1:0] MEM_SIZE    = ADDR_W'(32'h0800_0000),
    parameter int                WAIT_CYCLES = 0,
    parameter int                RR_MODE     = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_MASTERS-1:0]        I_m_req,
    input  logic [NUM_MASTERS-1:0]        I_m_we,
    input  logic [NUM_MASTERS*ADDR_W-1:0] I_m_addr,
    input  logic [NUM_MASTERS*DATA_W-1:0] I_m_wdata,
    input  logic [NUM_MASTERS*MASK_W-1:0] I_m_mask,
    output logic [DATA_W-1:0]             O_m_rdata,
    output logic [NUM_MASTERS-1:0]        O_m_ready,
    output logic [NUM_MASTERS-1:0]        O_m_err,
    output logic                          O_mem_req,
    output logic                          O_mem_we,
    output logic [ADDR_W-1:0]             O_mem_addr,
    output logic [DATA_W-1:0]             O_mem_wdata,
    output logic [MASK_W-1:0]             O_mem_mask,
    input  logic [DATA_W-1:0]             I_mem_rdata
);

    // A single master still needs a 1-bit index so the grant register exists.
    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    // The wait counter is loaded with WAIT_CYCLES-1 and counts down to zero.
    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    // After reset the pointer sits on the last master so master 0 wins first.
    localparam logic [IDX_W-1:0] PTR_INIT = IDX_W'(NUM_MASTERS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [IDX_W-1:0]  rr_ptr_q;
    logic [IDX_W-1:0]  grant_q;
    logic              we_q;
    logic [ADDR_W-1:0] offset_q;
    logic [DATA_W-1:0] wdata_q;
    logic [MASK_W-1:0] mask_q;
    logic              err_q;
    logic [DATA_W-1:0] rdata_q;
    logic [3:0]        wait_cnt_q;

    logic              grant_valid;
    logic [IDX_W-1:0]  grant_idx;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [MASK_W-1:0] sel_mask;
    logic [ADDR_W-1:0] sel_offset;
    logic              sel_err;

    // Pick a winner: in round-robin mode prefer the lowest requester above the pointer,
    // otherwise (or on wrap-around) the lowest requester overall.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        if (RR_MODE != 0) begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (!grant_valid && I_m_req[i] && (IDX_W'(i) > rr_ptr_q)) begin
                    grant_valid = 1'b1;
                    grant_idx   = IDX_W'(i);
                end
            end
        end
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!grant_valid && I_m_req[i]) begin
                grant_valid = 1'b1;
                grant_idx   = IDX_W'(i);
            end
        end
    end

    // Mux out the winning master's fields and work out the rebased address and range check.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_mask  = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant_idx == IDX_W'(i)) begin
                sel_we    = I_m_we[i];
                sel_addr  = I_m_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = I_m_wdata[i*DATA_W +: DATA_W];
                sel_mask  = I_m_mask[i*MASK_W +: MASK_W];
            end
        end
        // Unsigned wrap makes addresses below the base look huge, hence out of range.
        sel_offset = sel_addr - BASE_ADDR;
        sel_err    = (sel_offset >= MEM_SIZE);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: one pass IDLE -> (WAIT) -> ACCESS -> RESP -> IDLE per transaction.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    state_d = (WAIT_CYCLES > 0) ? WAIT : ACCESS;
                end
            end
            WAIT: begin
                if (wait_cnt_q == 4'd0) begin
                    state_d = ACCESS;
                end
            end
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Latch the granted request, run the wait counter and capture read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q   <= PTR_INIT;
            grant_q    <= '0;
            we_q       <= 1'b0;
            offset_q   <= '0;
            wdata_q    <= '0;
            mask_q     <= '0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            wait_cnt_q <= 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_valid) begin
                        rr_ptr_q   <= grant_idx;
                        grant_q    <= grant_idx;
                        we_q       <= sel_we;
                        offset_q   <= sel_offset;
                        wdata_q    <= sel_wdata;
                        mask_q     <= sel_mask;
                        err_q      <= sel_err;
                        rdata_q    <= '0;
                        wait_cnt_q <= WAIT_INIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt_q != 4'd0) begin
                        wait_cnt_q <= wait_cnt_q - 4'd1;
                    end
                end
                ACCESS: begin
                    rdata_q <= (!err_q && !we_q) ? I_mem_rdata : '0;
                end
                default: begin
                end
            endcase
        end
    end

    // Drive the downstream strobe in ACCESS and the upstream response in RESP; zero otherwise.
    always_comb begin
        O_mem_req   = 1'b0;
        O_mem_we    = 1'b0;
        O_mem_addr  = '0;
        O_mem_wdata = '0;
        O_mem_mask  = '0;
        O_m_ready   = '0;
        O_m_err     = '0;
        O_m_rdata   = '0;
        if (state_q == ACCESS && !err_q) begin
            O_mem_req   = 1'b1;
            O_mem_we    = we_q;
            O_mem_addr  = offset_q;
            O_mem_wdata = wdata_q;
            O_mem_mask  = mask_q;
        end
        if (state_q == RESP) begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                O_m_ready[i] = (grant_q == IDX_W'(i));
                O_m_err[i]   = (grant_q == IDX_W'(i)) && err_q;
            end
            O_m_rdata = rdata_q;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed checks of four arbiter configurations sharing one clock.
// dut_a: W=0 round robin, dut_b: W=3 round robin, dut_c: W=0 fixed priority,
// dut_d: W=5 round robin. Each instance has its own stimulus and reset.
module tb_mem_bus_arbiter;

    logic        clk;
    logic        rst       [4];
    logic [1:0]  req       [4];
    logic [1:0]  we        [4];
    logic [63:0] addr      [4];
    logic [63:0] wdata     [4];
    logic [7:0]  mask      [4];
    logic [31:0] mem_rdata [4];
    logic [31:0] rdata     [4];
    logic [1:0]  ready     [4];
    logic [1:0]  err       [4];
    logic        mem_req   [4];
    logic        mem_we    [4];
    logic [31:0] mem_addr  [4];
    logic [31:0] mem_wdata [4];
    logic [3:0]  mem_mask  [4];

    int checks = 0;
    int errors = 0;

    mem_bus_arbiter #(.WAIT_CYCLES(0), .RR_MODE(1)) dut_a (
        .clk(clk), .rst(rst[0]), .I_m_req(req[0]), .I_m_we(we[0]), .I_m_addr(addr[0]),
        .I_m_wdata(wdata[0]), .I_m_mask(mask[0]), .O_m_rdata(rdata[0]), .O_m_ready(ready[0]),
        .O_m_err(err[0]), .O_mem_req(mem_req[0]), .O_mem_we(mem_we[0]), .O_mem_addr(mem_addr[0]),
        .O_mem_wdata(mem_wdata[0]), .O_mem_mask(mem_mask[0]), .I_mem_rdata(mem_rdata[0])
    );

    mem_bus_arbiter #(.WAIT_CYCLES(3), .RR_MODE(1)) dut_b (
        .clk(clk), .rst(rst[1]), .I_m_req(req[1]), .I_m_we(we[1]), .I_m_addr(addr[1]),
        .I_m_wdata(wdata[1]), .I_m_mask(mask[1]), .O_m_rdata(rdata[1]), .O_m_ready(ready[1]),
        .O_m_err(err[1]), .O_mem_req(mem_req[1]), .O_mem_we(mem_we[1]), .O_mem_addr(mem_addr[1]),
        .O_mem_wdata(mem_wdata[1]), .O_mem_mask(mem_mask[1]), .I_mem_rdata(mem_rdata[1])
    );

    mem_bus_arbiter #(.WAIT_CYCLES(0), .RR_MODE(0)) dut_c (
        .clk(clk), .rst(rst[2]), .I_m_req(req[2]), .I_m_we(we[2]), .I_m_addr(addr[2]),
        .I_m_wdata(wdata[2]), .I_m_mask(mask[2]), .O_m_rdata(rdata[2]), .O_m_ready(ready[2]),
        .O_m_err(err[2]), .O_mem_req(mem_req[2]), .O_mem_we(mem_we[2]), .O_mem_addr(mem_addr[2]),
        .O_mem_wdata(mem_wdata[2]), .O_mem_mask(mem_mask[2]), .I_mem_rdata(mem_rdata[2])
    );

    mem_bus_arbiter #(.WAIT_CYCLES(5), .RR_MODE(1)) dut_d (
        .clk(clk), .rst(rst[3]), .I_m_req(req[3]), .I_m_we(we[3]), .I_m_addr(addr[3]),
        .I_m_wdata(wdata[3]), .I_m_mask(mask[3]), .O_m_rdata(rdata[3]), .O_m_ready(ready[3]),
        .O_m_err(err[3]), .O_mem_req(mem_req[3]), .O_mem_we(mem_we[3]), .O_mem_addr(mem_addr[3]),
        .O_mem_wdata(mem_wdata[3]), .O_mem_mask(mem_mask[3]), .I_mem_rdata(mem_rdata[3])
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance past the next rising edge; outputs are settled and new inputs may be driven.
    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    // Drive the request and write-enable vectors of one instance.
    task automatic applyStimulus(input int d, input logic [1:0] req_v, input logic [1:0] we_v);
        req[d] = req_v;
        we[d]  = we_v;
    endtask

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Directed sequence covering reset, reads, writes, contention, range errors and reset aborts.
    initial begin
        for (int d = 0; d < 4; d++) begin
            rst[d]       = 1'b1;
            req[d]       = 2'b00;
            we[d]        = 2'b00;
            addr[d]      = '0;
            wdata[d]     = '0;
            mask[d]      = '0;
            mem_rdata[d] = 32'hDEAD_BEEF;
        end
        stepClock();
        stepClock();

        $display("[TB] reset values");
        checkOutput("rst_ready", 64'(ready[0]), 64'h0);
        checkOutput("rst_err", 64'(err[0]), 64'h0);
        checkOutput("rst_rdata", 64'(rdata[0]), 64'h0);
        checkOutput("rst_mem_req", 64'(mem_req[0]), 64'h0);
        checkOutput("rst_mem_addr", 64'(mem_addr[0]), 64'h0);
        for (int d = 0; d < 4; d++) rst[d] = 1'b0;

        $display("[TB] single read, W=0");
        addr[0] = {32'h0, 32'h8000_0010};
        applyStimulus(0, 2'b01, 2'b00);
        stepClock();
        checkOutput("rd_mem_req", 64'(mem_req[0]), 64'h1);
        checkOutput("rd_mem_addr", 64'(mem_addr[0]), 64'h10);
        checkOutput("rd_mem_we", 64'(mem_we[0]), 64'h0);
        stepClock();
        checkOutput("rd_ready", 64'(ready[0]), 64'h1);
        checkOutput("rd_rdata", 64'(rdata[0]), 64'hDEAD_BEEF);
        checkOutput("rd_err", 64'(err[0]), 64'h0);
        applyStimulus(0, 2'b00, 2'b00);
        stepClock();
        checkOutput("rd_ready_done", 64'(ready[0]), 64'h0);

        $display("[TB] write, W=3");
        addr[1]  = {32'h8000_0004, 32'h0};
        wdata[1] = {32'h1234_5678, 32'h0};
        mask[1]  = {4'b0011, 4'b0000};
        applyStimulus(1, 2'b10, 2'b10);
        for (int c = 1; c <= 3; c++) begin
            stepClock();
            checkOutput("wr_wait_mem_req", 64'(mem_req[1]), 64'h0);
        end
        stepClock();
        checkOutput("wr_mem_req", 64'(mem_req[1]), 64'h1);
        checkOutput("wr_mem_we", 64'(mem_we[1]), 64'h1);
        checkOutput("wr_mem_addr", 64'(mem_addr[1]), 64'h4);
        checkOutput("wr_mem_wdata", 64'(mem_wdata[1]), 64'h1234_5678);
        checkOutput("wr_mem_mask", 64'(mem_mask[1]), 64'h3);
        stepClock();
        checkOutput("wr_ready", 64'(ready[1]), 64'h2);
        checkOutput("wr_rdata", 64'(rdata[1]), 64'h0);
        applyStimulus(1, 2'b00, 2'b00);
        stepClock();

        // dut_a's pointer now sits on master 0, so master 1 wins first there.
        $display("[TB] contention, round robin vs fixed priority");
        addr[0] = {32'h8000_0200, 32'h8000_0100};
        addr[2] = {32'h8000_0200, 32'h8000_0100};
        applyStimulus(0, 2'b11, 2'b00);
        applyStimulus(2, 2'b11, 2'b00);
        for (int n = 0; n < 4; n++) begin
            stepClock();
            checkOutput("rr_mem_addr", 64'(mem_addr[0]), (n % 2 == 0) ? 64'h200 : 64'h100);
            checkOutput("fix_mem_addr", 64'(mem_addr[2]), 64'h100);
            stepClock();
            checkOutput("rr_ready", 64'(ready[0]), (n % 2 == 0) ? 64'h2 : 64'h1);
            checkOutput("fix_ready", 64'(ready[2]), 64'h1);
            stepClock();
            checkOutput("rr_idle_ready", 64'(ready[0]), 64'h0);
            checkOutput("rr_idle_mem_req", 64'(mem_req[0]), 64'h0);
        end
        applyStimulus(0, 2'b00, 2'b00);
        applyStimulus(2, 2'b00, 2'b00);
        stepClock();

        $display("[TB] out of range and last in-range word");
        addr[0] = {32'h8800_0000, 32'h7FFF_FFFC};
        applyStimulus(0, 2'b01, 2'b00);
        stepClock();
        checkOutput("oor_lo_mem_req", 64'(mem_req[0]), 64'h0);
        stepClock();
        checkOutput("oor_lo_ready", 64'(ready[0]), 64'h1);
        checkOutput("oor_lo_err", 64'(err[0]), 64'h1);
        checkOutput("oor_lo_rdata", 64'(rdata[0]), 64'h0);
        applyStimulus(0, 2'b00, 2'b00);
        stepClock();
        checkOutput("oor_lo_err_done", 64'(err[0]), 64'h0);
        applyStimulus(0, 2'b10, 2'b00);
        stepClock();
        checkOutput("oor_hi_mem_req", 64'(mem_req[0]), 64'h0);
        stepClock();
        checkOutput("oor_hi_ready", 64'(ready[0]), 64'h2);
        checkOutput("oor_hi_err", 64'(err[0]), 64'h2);
        checkOutput("oor_hi_rdata", 64'(rdata[0]), 64'h0);
        applyStimulus(0, 2'b00, 2'b00);
        stepClock();
        addr[0] = {32'h0, 32'h87FF_FFFC};
        applyStimulus(0, 2'b01, 2'b00);
        stepClock();
        checkOutput("edge_mem_req", 64'(mem_req[0]), 64'h1);
        checkOutput("edge_mem_addr", 64'(mem_addr[0]), 64'h07FF_FFFC);
        stepClock();
        checkOutput("edge_ready", 64'(ready[0]), 64'h1);
        checkOutput("edge_err", 64'(err[0]), 64'h0);
        checkOutput("edge_rdata", 64'(rdata[0]), 64'hDEAD_BEEF);
        applyStimulus(0, 2'b00, 2'b00);
        stepClock();

        $display("[TB] reset during wait, W=5");
        addr[3] = {32'h8000_0040, 32'h8000_0020};
        applyStimulus(3, 2'b01, 2'b00);
        for (int c = 0; c < 3; c++) stepClock();
        checkOutput("abort_wait_mem_req", 64'(mem_req[3]), 64'h0);
        rst[3] = 1'b1;
        applyStimulus(3, 2'b00, 2'b00);
        stepClock();
        rst[3] = 1'b0;
        for (int c = 0; c < 8; c++) begin
            stepClock();
            checkOutput("abort_mem_req", 64'(mem_req[3]), 64'h0);
            checkOutput("abort_ready", 64'(ready[3]), 64'h0);
        end
        applyStimulus(3, 2'b11, 2'b00);
        for (int c = 0; c < 5; c++) begin
            stepClock();
            checkOutput("post_rst_wait", 64'(mem_req[3]), 64'h0);
        end
        stepClock();
        checkOutput("post_rst_mem_req", 64'(mem_req[3]), 64'h1);
        checkOutput("post_rst_mem_addr", 64'(mem_addr[3]), 64'h20);
        stepClock();
        checkOutput("post_rst_ready", 64'(ready[3]), 64'h1);
        applyStimulus(3, 2'b00, 2'b00);
        stepClock();

        // Inputs are scrambled after the grant to show only latched values are used.
        $display("[TB] early request drop, zero-mask write, W=3");
        addr[1]  = {32'h0, 32'h8000_0008};
        wdata[1] = {32'h0, 32'hCAFE_F00D};
        mask[1]  = 8'h00;
        applyStimulus(1, 2'b01, 2'b01);
        stepClock();
        checkOutput("drop_grant_mem_req", 64'(mem_req[1]), 64'h0);
        applyStimulus(1, 2'b00, 2'b00);
        addr[1]  = {32'h0, 32'h8000_0FF0};
        wdata[1] = '0;
        mask[1]  = 8'hFF;
        for (int c = 0; c < 2; c++) begin
            stepClock();
            checkOutput("drop_wait_mem_req", 64'(mem_req[1]), 64'h0);
        end
        stepClock();
        checkOutput("drop_mem_req", 64'(mem_req[1]), 64'h1);
        checkOutput("drop_mem_we", 64'(mem_we[1]), 64'h1);
        checkOutput("drop_mem_addr", 64'(mem_addr[1]), 64'h8);
        checkOutput("drop_mem_wdata", 64'(mem_wdata[1]), 64'hCAFE_F00D);
        checkOutput("drop_mem_mask", 64'(mem_mask[1]), 64'h0);
        stepClock();
        checkOutput("drop_ready", 64'(ready[1]), 64'h1);
        checkOutput("drop_err", 64'(err[1]), 64'h0);
        checkOutput("drop_rdata", 64'(rdata[1]), 64'h0);
        stepClock();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
